// File: rtl/module_numero.sv
// Keypad number entry: debounced-edge key accept, BCD digit buffer with
// backspace/clear, and a fixed-latency BCD-to-binary conversion on ENTER.
module module_numero #(
  parameter int N_DIGITS = 3,
  parameter int BIN_W    = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             key_valid_i,
  input  logic [1:0]                       dato_codc_i,
  input  logic [1:0]                       dato_codf_i,
  output logic [4*N_DIGITS-1:0]            digits_o,
  output logic [$clog2(N_DIGITS+1)-1:0]    count_o,
  output logic [BIN_W-1:0]                 numero_o,
  output logic                             numero_valid_o,
  output logic                             busy_o,
  output logic                             err_o
);

  localparam int CNT_W = $clog2(N_DIGITS+1);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW    = 4*N_DIGITS;

  typedef enum logic [1:0] {ENTRY = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              key_prev_q;
  logic              accept;
  logic [3:0]        pos;
  logic              is_digit, is_clear, is_enter, is_bksp;
  logic [3:0]        dig;
  logic [3:0]        nib;
  logic [DW-1:0]     digits_q, digits_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BIN_W-1:0]  acc_q, acc_d, numero_q, numero_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              fin_q, fin_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;

  assign pos    = {dato_codc_i, dato_codf_i};
  assign accept = key_valid_i & ~key_prev_q;

  always_comb begin
    is_digit = 1'b0;
    is_clear = 1'b0;
    is_enter = 1'b0;
    is_bksp  = 1'b0;
    dig      = '0;
    case (pos)
      4'd0:    begin is_digit = 1'b1; dig = 4'd1; end
      4'd1:    begin is_digit = 1'b1; dig = 4'd4; end
      4'd2:    begin is_digit = 1'b1; dig = 4'd7; end
      4'd4:    begin is_digit = 1'b1; dig = 4'd2; end
      4'd5:    begin is_digit = 1'b1; dig = 4'd5; end
      4'd6:    begin is_digit = 1'b1; dig = 4'd8; end
      4'd8:    begin is_digit = 1'b1; dig = 4'd3; end
      4'd9:    begin is_digit = 1'b1; dig = 4'd6; end
      4'd10:   begin is_digit = 1'b1; dig = 4'd9; end
      4'd7:    begin is_digit = 1'b1; dig = 4'd0; end
      4'd3:    is_clear = 1'b1;
      4'd11:   is_enter = 1'b1;
      4'd15:   is_bksp  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    nib = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) nib = digits_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    fin_d    = fin_q;
    numero_d = numero_q;
    err_d    = 1'b0;
    case (state_q)
      ENTRY: begin
        if (accept) begin
          if (is_digit) begin
            if (count_q == CNT_W'(N_DIGITS)) begin
              err_d = 1'b1;
            end else begin
              digits_d = (digits_q << 4) | DW'(dig);
              count_d  = count_q + CNT_W'(1);
            end
          end else if (is_bksp) begin
            if (count_q == '0) begin
              err_d = 1'b1;
            end else begin
              digits_d = digits_q >> 4;
              count_d  = count_q - CNT_W'(1);
            end
          end else if (is_clear) begin
            digits_d = '0;
            count_d  = '0;
          end else if (is_enter) begin
            if (count_q == '0) begin
              err_d = 1'b1;
            end else begin
              state_d = CONV;
              acc_d   = '0;
              idx_d   = IDX_W'(N_DIGITS-1);
              fin_d   = 1'b0;
            end
          end
        end
      end
      CONV: begin
        // One extra cycle after the last nibble publishes the result, so the
        // DONE pulse lands N_DIGITS+1 edges after the ENTER accept.
        if (fin_q) begin
          numero_d = acc_q;
          state_d  = DONE;
        end else begin
          acc_d = acc_q * BIN_W'(10) + BIN_W'(nib);
          if (idx_q == '0) fin_d = 1'b1;
          else             idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        state_d  = ENTRY;
        digits_d = '0;
        count_d  = '0;
      end
      default: state_d = ENTRY;
    endcase
  end

  assign valid_d = (state_q == CONV) && fin_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ENTRY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_prev_q <= 1'b1;
      digits_q   <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      fin_q      <= 1'b0;
      numero_q   <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      key_prev_q <= key_valid_i;
      digits_q   <= digits_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      fin_q      <= fin_d;
      numero_q   <= numero_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  assign digits_o       = digits_q;
  assign count_o        = count_q;
  assign numero_o       = numero_q;
  assign numero_valid_o = valid_q;
  assign busy_o         = (state_q != ENTRY);
  assign err_o          = err_q;

endmodule

// File: tb/tb_module_numero.sv
// Scoreboard bench for module_numero: key presses push expected err/numero
// pulses (value and arrival cycle); a negedge monitor pops and compares.
module tb_module_numero;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid_i = 1'b0;
  logic [1:0]  dato_codc_i = '0;
  logic [1:0]  dato_codf_i = '0;
  logic [11:0] digits_o;
  logic [1:0]  count_o;
  logic [9:0]  numero_o;
  logic        numero_valid_o;
  logic        busy_o;
  logic        err_o;

  module_numero #(.N_DIGITS(3), .BIN_W(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid_i    (key_valid_i),
    .dato_codc_i    (dato_codc_i),
    .dato_codf_i    (dato_codf_i),
    .digits_o       (digits_o),
    .count_o        (count_o),
    .numero_o       (numero_o),
    .numero_valid_o (numero_valid_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [9:0]  val;
  } num_exp_t;

  num_exp_t    num_q[$];
  int unsigned err_q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every err/numero_valid pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_o) begin
        if (err_q.size() == 0) check("unexpected_err", 32'd1, 32'd0);
        else check("err_cycle", cyc, err_q.pop_front());
      end
      if (numero_valid_o) begin
        if (num_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else begin
          num_exp_t e;
          e = num_q.pop_front();
          check("numero_cycle", cyc, e.due);
          check("numero_value", {22'd0, numero_o}, {22'd0, e.val});
        end
      end
    end
  end

  // Key is driven at a negedge (cycle c); accept happens on the next edge.
  task automatic press(input logic [3:0] pos, input int hold,
                       input bit exp_err, input bit exp_num, input logic [9:0] val);
    @(negedge clk);
    {dato_codc_i, dato_codf_i} = pos;
    key_valid_i = 1'b1;
    if (exp_err) err_q.push_back(cyc + 1);
    if (exp_num) num_q.push_back('{cyc + 5, val});
    repeat (hold) @(negedge clk);
    key_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy_o && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_digits", {20'd0, digits_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_digits", {20'd0, digits_o}, 32'd0);
    check("reset_count", {30'd0, count_o}, 32'd0);
    check("reset_numero", {22'd0, numero_o}, 32'd0);
    check("reset_outs", {29'd0, busy_o, err_o, numero_valid_o}, 32'd0);

    // 1 2 3 ENTER
    press(4'd0, 1, 0, 0, '0);
    press(4'd4, 1, 0, 0, '0);
    press(4'd8, 1, 0, 0, '0);
    check("digits_123", {20'd0, digits_o}, 32'h123);
    check("count_3", {30'd0, count_o}, 32'd3);
    press(4'd11, 1, 0, 1, 10'd123);
    check("busy_conv", {31'd0, busy_o}, 32'd1);
    wait_idle();
    check("post_done_digits", {20'd0, digits_o}, 32'd0);
    check("post_done_count", {30'd0, count_o}, 32'd0);
    check("numero_hold", {22'd0, numero_o}, 32'd123);

    // Held key: single accept
    press(4'd5, 20, 0, 0, '0);
    check("held_digits", {20'd0, digits_o}, 32'h005);
    check("held_count", {30'd0, count_o}, 32'd1);
    press(4'd3, 1, 0, 0, '0);
    check("clear_digits", {20'd0, digits_o}, 32'd0);
    check("clear_count", {30'd0, count_o}, 32'd0);

    // Overflow of the digit buffer
    press(4'd10, 1, 0, 0, '0);
    press(4'd10, 1, 0, 0, '0);
    press(4'd10, 1, 0, 0, '0);
    press(4'd7, 1, 1, 0, '0);
    check("full_digits", {20'd0, digits_o}, 32'h999);
    check("full_count", {30'd0, count_o}, 32'd3);
    press(4'd11, 1, 0, 1, 10'd999);
    wait_idle();

    // Backspace sequence
    press(4'd1, 1, 0, 0, '0);
    press(4'd5, 1, 0, 0, '0);
    press(4'd15, 1, 0, 0, '0);
    press(4'd9, 1, 0, 0, '0);
    check("bksp_digits", {20'd0, digits_o}, 32'h046);
    press(4'd15, 1, 0, 0, '0);
    press(4'd15, 1, 0, 0, '0);
    check("bksp_count0", {30'd0, count_o}, 32'd0);
    press(4'd15, 1, 1, 0, '0);
    press(4'd15, 1, 1, 0, '0);
    check("bksp_empty_count", {30'd0, count_o}, 32'd0);

    // ENTER on empty buffer, ignored key
    press(4'd11, 1, 1, 0, '0);
    check("empty_enter_busy", {31'd0, busy_o}, 32'd0);
    press(4'd12, 1, 0, 0, '0);
    check("ignored_key_count", {30'd0, count_o}, 32'd0);

    // Leading zero: 0 7 -> 7
    press(4'd7, 1, 0, 0, '0);
    press(4'd2, 1, 0, 0, '0);
    check("zero_lead_digits", {20'd0, digits_o}, 32'h007);
    press(4'd11, 1, 0, 1, 10'd7);
    wait_idle();

    // Key pressed while busy is discarded
    press(4'd0, 1, 0, 0, '0);
    press(4'd11, 1, 0, 1, 10'd1);
    check("busy_before_key", {31'd0, busy_o}, 32'd1);
    press(4'd4, 1, 0, 0, '0);
    wait_idle();
    check("busy_key_digits", {20'd0, digits_o}, 32'd0);
    check("busy_key_count", {30'd0, count_o}, 32'd0);

    // Reset mid-conversion, then a key held across reset release
    press(4'd1, 1, 0, 0, '0);
    press(4'd2, 1, 0, 0, '0);
    check("pre_abort_digits", {20'd0, digits_o}, 32'h047);
    @(negedge clk);
    {dato_codc_i, dato_codf_i} = 4'd11;
    key_valid_i = 1'b1;
    @(negedge clk);
    key_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    {dato_codc_i, dato_codf_i} = 4'd0;
    key_valid_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_digits", {20'd0, digits_o}, 32'd0);
    check("abort_count", {30'd0, count_o}, 32'd0);
    check("abort_numero", {22'd0, numero_o}, 32'd0);
    check("abort_outs", {29'd0, busy_o, err_o, numero_valid_o}, 32'd0);
    key_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("held_through_rst_count", {30'd0, count_o}, 32'd0);

    repeat (10) @(negedge clk);
    check("pending_numero", num_q.size(), 32'd0);
    check("pending_err", err_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
